// File: rtl/thermo_bargraph.sv
// Thermometer-coded level to 8-LED bar graph, with a double-scale mode and a
// blinking full/empty bar while the input code is illegal.
module thermo_bargraph #(
  parameter int BLINK_DIV = 8
) (
  input  logic       Clk_in,
  input  logic       nRst_in,
  input  logic [3:0] Thermo_in,
  input  logic       Turbo_in,
  output logic       Err_out,
  output logic [7:0] BGraph_out
);

  localparam int CNT_W = $clog2(BLINK_DIV) + 1;

  logic             err_q, err_d;
  logic [7:0]       bgraph_q, bgraph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  logic       legal;
  logic [2:0] level;
  logic [3:0] span;
  logic [7:0] graph;

  always_comb begin
    legal = 1'b1;
    level = 3'd0;
    case (Thermo_in)
      4'b0000: level = 3'd0;
      4'b0001: level = 3'd1;
      4'b0011: level = 3'd2;
      4'b0111: level = 3'd3;
      4'b1111: level = 3'd4;
      default: legal = 1'b0;
    endcase
  end

  // Number of lit LEDs: L in normal mode, 2L in turbo mode.
  assign span = Turbo_in ? {level, 1'b0} : {1'b0, level};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bar
      assign graph[gi] = (span > 4'(gi));
    end
  endgenerate

  always_comb begin
    err_d    = err_q;
    bgraph_d = bgraph_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (legal) begin
      err_d    = 1'b0;
      bgraph_d = graph;
      cnt_d    = '0;
      phase_d  = 1'b0;
    end else begin
      err_d = 1'b1;
      // err_q low means the previous sample was legal (or we just left reset).
      if (!err_q) begin
        cnt_d   = CNT_W'(1);
        phase_d = 1'b1;
      end else if (cnt_q == CNT_W'(BLINK_DIV)) begin
        cnt_d   = CNT_W'(1);
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      bgraph_d = phase_d ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (!nRst_in) begin
      err_q    <= 1'b0;
      bgraph_q <= 8'h00;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      err_q    <= err_d;
      bgraph_q <= bgraph_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign Err_out    = err_q;
  assign BGraph_out = bgraph_q;

endmodule

// File: tb/tb_thermo_bargraph.sv
// Self-checking bench for thermo_bargraph: directed vector table, hand-written
// blink/exit/reset sequences, and randomized traffic against a reference model.
module tb_thermo_bargraph;

  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] thermo;
  logic       turbo;
  logic       err;
  logic [7:0] bg;

  int total = 0;
  int bad   = 0;

  // Reference model state: length of the current run of illegal samples.
  int         run = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_bg = 8'h00;

  thermo_bargraph #(.BLINK_DIV(BLINK_DIV)) dut (
    .Clk_in    (clk),
    .nRst_in   (nrst),
    .Thermo_in (thermo),
    .Turbo_in  (turbo),
    .Err_out   (err),
    .BGraph_out(bg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] th;
    logic       tu;
    logic       er;
    logic [7:0] bgx;
  } vec_t;

  vec_t vecs[12];

  function automatic bit is_legal(input logic [3:0] t);
    int n = $countones(t);
    return int'(t) == ((1 << n) - 1);
  endfunction

  task automatic model_step();
    if (!nrst) begin
      run = 0; m_err = 1'b0; m_bg = 8'h00;
    end else if (is_legal(thermo)) begin
      int n = $countones(thermo) * (turbo ? 2 : 1);
      run = 0; m_err = 1'b0; m_bg = 8'((1 << n) - 1);
    end else begin
      run++;
      m_err = 1'b1;
      m_bg = (((run - 1) / BLINK_DIV) % 2 == 0) ? 8'hFF : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic got_e, input logic [7:0] got_b,
                     input logic exp_e, input logic [7:0] exp_b);
    total++;
    if (got_e !== exp_e || got_b !== exp_b) begin
      bad++;
      $display("FAIL %s: err=%b bg=%h, want err=%b bg=%h", name, got_e, got_b, exp_e, exp_b);
    end else begin
      $display("ok   %s: th=%b tu=%b err=%b bg=%h", name, thermo, turbo, got_e, got_b);
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{4'b0001, 1'b0, 1'b0, 8'h01};
    vecs[2]  = '{4'b0011, 1'b0, 1'b0, 8'h03};
    vecs[3]  = '{4'b0111, 1'b0, 1'b0, 8'h07};
    vecs[4]  = '{4'b1111, 1'b0, 1'b0, 8'h0F};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{4'b0001, 1'b1, 1'b0, 8'h03};
    vecs[7]  = '{4'b0011, 1'b1, 1'b0, 8'h0F};
    vecs[8]  = '{4'b0111, 1'b1, 1'b0, 8'h3F};
    vecs[9]  = '{4'b1111, 1'b1, 1'b0, 8'hFF};
    vecs[10] = '{4'b0011, 1'b0, 1'b0, 8'h03};
    vecs[11] = '{4'b0011, 1'b1, 1'b0, 8'h0F};

    nrst = 1'b0; thermo = 4'b0000; turbo = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    chk("reset_state", err, bg, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      thermo = vecs[i].th; turbo = vecs[i].tu;
      tick();
      chk($sformatf("vec%0d", i), err, bg, vecs[i].er, vecs[i].bgx);
    end

    // Blink: 8 on, 8 off, on again; code switch at k=12 must not restart.
    for (int k = 0; k < 20; k++) begin
      thermo = (k < 12) ? 4'b0100 : 4'b1000;
      turbo  = k[0];
      tick();
      chk($sformatf("blink%0d", k), err, bg, 1'b1,
          (k < BLINK_DIV || k >= 2 * BLINK_DIV) ? 8'hFF : 8'h00);
    end

    // Error exit after 5 cycles, then a fresh full on-phase.
    thermo = 4'b0001; turbo = 1'b0; tick();
    thermo = 4'b0100;
    for (int k = 0; k < 5; k++) tick();
    thermo = 4'b0001; turbo = 1'b1; tick();
    chk("exit", err, bg, 1'b0, 8'h03);
    thermo = 4'b0110;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("restart%0d", k), err, bg, 1'b1, (k < BLINK_DIV) ? 8'hFF : 8'h00);
    end

    // Reset during the off phase, release with the illegal code still present.
    nrst = 1'b0; tick();
    chk("rst_mid", err, bg, 1'b0, 8'h00);
    nrst = 1'b1; tick();
    chk("rst_release", err, bg, 1'b1, 8'hFF);

    // Randomized traffic; codes tend to persist so long error runs occur.
    for (int c = 0; c < 3000; c++) begin
      nrst = ($urandom_range(99) != 0);
      if ($urandom_range(99) < (is_legal(thermo) ? 30 : 8)) begin
        if ($urandom_range(1)) thermo = 4'($urandom_range(15));
        else thermo = 4'((1 << $urandom_range(4)) - 1);
      end
      if ($urandom_range(9) == 0) turbo = ~turbo;
      tick();
      chk($sformatf("rnd%0d", c), err, bg, m_err, m_bg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
